byte_mem: RTL and testbench
===========================

BYTE_MEM -- requirements
Module: byte_mem

Interface
REQ-001 SHALL have parameter: ADDR_W, 14, byte-address width; word depth DEPTH = 2**(ADDR_W-2).
REQ-002 SHALL have parameter: INIT_CLEAR, 1, 1 = run zero-fill sequence after reset; 0 = skip it (busy never asserted).
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: address  in  ADDR_W  byte address.
REQ-006 SHALL have port: mem_write  in  1  store request, sampled at rising edge.
REQ-007 SHALL have port: mem_read  in  1  load request, sampled at rising edge.
REQ-008 SHALL have port: funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port: write_data  in  32  store data, LSB-justified.
REQ-010 SHALL have port: read_data  out  32  registered, extended load result.
REQ-011 SHALL have port: rd_valid  out  1  one-cycle pulse, read_data updated.
REQ-012 SHALL have port: busy  out  1  zero-fill in progress; requests ignored.
REQ-013 SHALL have port: misalign  out  1  one-cycle pulse, misaligned access rejected.

Function
REQ-014 SHALL run FSM INIT->IDLE: INIT writes 0 to word clr_cnt per cycle and increments clr_cnt; after word DEPTH-1, goes to IDLE next cycle; busy=1 exactly in INIT.
REQ-015 SHALL ignore mem_read/mem_write while busy=1: no memory update, no rd_valid, no misalign.
REQ-016 SHALL index word = address[ADDR_W-1:2], lane = address[1:0].
REQ-017 SHALL on store: SB writes write_data[7:0] to lane; SH writes write_data[15:0] to half address[1]; SW writes full word; other lanes unchanged.
REQ-018 SHALL on load: read_data and rd_valid=1 one cycle after request; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-019 SHALL hold read_data between loads; rd_valid=0 when no load completes.
REQ-020 SHALL treat funct3 011/110/111 as no-op: no write, no rd_valid, no misalign.
REQ-021 SHALL, on simultaneous mem_read and mem_write, perform both; read returns pre-write contents.
REQ-022 SHALL define misaligned: H/HU with address[0]=1; W with address[1:0]!=0.
REQ-023 SHALL accept back-to-back loads/stores every cycle in IDLE.

Reset
REQ-024 SHALL on rst_n=0 immediately set read_data=0, rd_valid=0, misalign=0, clr_cnt=0, state=INIT (IDLE if INIT_CLEAR=0).
REQ-025 SHALL cancel any in-flight load on reset; no rd_valid after release.
REQ-026 SHALL not reset array asynchronously; contents zeroed only by INIT sequence; reset mid-INIT restarts at word 0.

Configuration
REQ-027 SHALL, with MISALIGN_TRAP_EN defined, suppress misaligned accesses (no write, no rd_valid) and pulse misalign one cycle after request.
REQ-028 SHALL, without MISALIGN_TRAP_EN, force alignment by ignoring low address bits (H: bit0, W: bits[1:0]) and tie misalign to 0.

Structure
REQ-029 SHALL place funct3 size encodings, mem_state_e (INIT, IDLE) and lane-select helpers in package mem_pkg.
REQ-030 SHALL implement load extension in combinational sub-module load_ext (word, lane, funct3 -> 32-bit result).

Verification (ADDR_W=8, DEPTH=64, MISALIGN_TRAP_EN defined unless stated)
REQ-031 SHALL cover: reset release -> busy=1 for 64 cycles then 0; LW @0x04 -> rd_valid next cycle, read_data 0x00000000.
REQ-032 SHALL cover: SW 0xA5A5A5A5 @0x04, LW @0x04 -> 0xA5A5A5A5; then SB 0xEE @0x05, LW @0x04 -> 0xA5A5EEA5; LB @0x05 -> 0xFFFFFFEE; LBU @0x05 -> 0x000000EE.
REQ-033 SHALL cover: SH 0xDEAD @0x0A; LH @0x0A -> 0xFFFFDEAD; LHU -> 0x0000DEAD; LW @0x08 -> 0xDEAD0000.
REQ-034 SHALL cover: LW @0x06 -> misalign=1 one cycle, rd_valid=0; without macro SW 0x12345678 @0x06 -> LW @0x04 returns 0x12345678.
REQ-035 SHALL cover: simultaneous LW+SW 0x11111111 @0x04 holding 0xA5A5A5A5 -> read_data 0xA5A5A5A5, next LW -> 0x11111111.
REQ-036 SHALL cover: rst_n=0 during cycle after LW request -> no rd_valid; after busy drops LW @0x04 -> 0x00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for byte_mem: RV32I funct3 sizes, FSM states,
// and per-lane byte-enable / data replication used by the store path.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } mem_state_e;

    function automatic logic f3_valid(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Forced alignment: halfwords drop bit 0, words drop both lane bits.
    function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lane);
        logic [1:0] al;
        case (f3)
            F3_H, F3_HU: al = {lane[1], 1'b0};
            F3_W:        al = 2'b00;
            default:     al = lane;
        endcase
        return al;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << lane;
            F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-justified store data so every enabled lane sees its bytes.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B, F3_BU: d = {4{wd[7:0]}};
            F3_H, F3_HU: d = {2{wd[15:0]}};
            default:     d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load extraction: selects byte/half/word from a memory word by lane
// and sign- or zero-extends it according to funct3. Zero latency, no flow control.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        result   = word;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/byte_mem.sv
// Byte-addressable RV32I data memory: zero-fills after reset, then serves one load/store
// per cycle with registered load data (1-cycle latency). MISALIGN_TRAP_EN selects trapping.
module byte_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [2:0]        funct3,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              misalign
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;

    mem_state_e        state, state_nxt;
    logic [WORD_W-1:0] clr_cnt, clr_cnt_nxt;

    logic [31:0]       mem [DEPTH];

    logic [WORD_W-1:0] word_idx;
    logic [1:0]        lane_raw;
    logic [1:0]        lane;
    logic              req_ok;
    logic              acc_ok;
    logic              mis_req;
    logic              wr_en;
    logic              rd_en;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       rd_word;
    logic [31:0]       ext_data;

    assign word_idx = address[ADDR_W-1:2];
    assign lane_raw = address[1:0];
    assign busy     = (state == INIT);
    assign req_ok   = (state == IDLE) && f3_valid(funct3);

`ifdef MISALIGN_TRAP_EN
    assign lane    = lane_raw;
    assign mis_req = req_ok && (mem_read || mem_write) && f3_misaligned(funct3, lane_raw);
    assign acc_ok  = req_ok && !f3_misaligned(funct3, lane_raw);
`else
    assign lane    = align_lane(funct3, lane_raw);
    assign mis_req = 1'b0;
    assign acc_ok  = req_ok;
`endif

    assign wr_en   = acc_ok && mem_write;
    assign rd_en   = acc_ok && mem_read;
    assign be      = lane_be(funct3, lane);
    assign wd      = lane_data(funct3, write_data);
    assign rd_word = mem[word_idx];

    load_ext u_load_ext (
        .word   (rd_word),
        .lane   (lane),
        .funct3 (funct3),
        .result (ext_data)
    );

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {WORD_W{1'b1}}) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT_CLEAR ? INIT : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Array has no reset; contents are only cleared by walking clr_cnt in INIT.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    // Load captures pre-write contents, so a same-cycle store is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
            rd_valid  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            misalign <= mis_req;
            if (rd_en) begin
                read_data <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_byte_mem.sv
// Directed bench for byte_mem (ADDR_W=8): zero-fill, sized loads/stores, misalignment,
// read-during-write and reset cancellation, each checked by immediate assertions.
module tb_byte_mem;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        busy;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    byte_mem #(.ADDR_W(8), .INIT_CLEAR(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .funct3     (funct3),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; outputs are valid on return (#1 after edge).
    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] d);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] exp);
        req(1'b1, 1'b0, f3, a, 32'h0);
        chk({tag, "_vld"}, {31'h0, rd_valid}, 32'h1);
        chk(tag, read_data, exp);
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] d);
        req(1'b0, 1'b1, f3, a, d);
        chk({tag, "_novld"}, {31'h0, rd_valid}, 32'h0);
    endtask

    // Counts edges until busy drops; optionally keeps a request asserted throughout.
    task automatic wait_init(input string tag, output int n, output logic saw_out);
        n = 0;
        saw_out = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (rd_valid || misalign) saw_out = 1'b1;
            if (!busy) break;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        int   n;
        logic saw;
        rst_n      = 1'b0;
        address    = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        funct3     = LW;
        write_data = '0;

        #3;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_cycles", n, saw);
        chk("init_quiet", {31'h0, saw}, 32'h0);

        load("lw_zero", LW, 8'h04, 32'h0000_0000);
        req(1'b0, 1'b0, LW, 8'h04, 32'h0);
        chk("idle_novld", {31'h0, rd_valid}, 32'h0);
        chk("idle_hold", read_data, 32'h0000_0000);

        store("sw_a5", LW, 8'h04, 32'hA5A5_A5A5);
        load("lw_a5", LW, 8'h04, 32'hA5A5_A5A5);
        store("sb_ee", LB, 8'h05, 32'h1234_56EE);
        load("lw_after_sb", LW, 8'h04, 32'hA5A5_EEA5);
        load("lb_ee", LB, 8'h05, 32'hFFFF_FFEE);
        load("lbu_ee", LBU, 8'h05, 32'h0000_00EE);

        store("sh_dead", LH, 8'h0A, 32'hFFFF_DEAD);
        load("lh_dead", LH, 8'h0A, 32'hFFFF_DEAD);
        load("lhu_dead", LHU, 8'h0A, 32'h0000_DEAD);
        load("lw_dead", LW, 8'h08, 32'hDEAD_0000);
        load("lb_lane3", LB, 8'h0B, 32'hFFFF_FFDE);

`ifdef MISALIGN_TRAP_EN
        req(1'b1, 1'b0, LW, 8'h06, 32'h0);
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_novld", {31'h0, rd_valid}, 32'h0);
        chk("mis_hold", read_data, 32'hFFFF_FFDE);
        req(1'b0, 1'b0, LW, 8'h06, 32'h0);
        chk("mis_oneshot", {31'h0, misalign}, 32'h0);
        req(1'b0, 1'b1, LW, 8'h06, 32'h1234_5678);
        chk("mis_sw_pulse", {31'h0, misalign}, 32'h1);
        load("mis_sw_nowrite", LW, 8'h04, 32'hA5A5_EEA5);
        req(1'b1, 1'b0, LH, 8'h0B, 32'h0);
        chk("mis_lh_pulse", {31'h0, misalign}, 32'h1);
`else
        load("lw_forced", LW, 8'h06, 32'hA5A5_EEA5);
        chk("lw_forced_nomis", {31'h0, misalign}, 32'h0);
        store("sw_forced", LW, 8'h06, 32'h1234_5678);
        load("lw_after_forced", LW, 8'h04, 32'h1234_5678);
        load("lh_forced", LHU, 8'h0B, 32'h0000_DEAD);
`endif

        req(1'b1, 1'b0, 3'b011, 8'h04, 32'h0);
        chk("f3_011_novld", {31'h0, rd_valid}, 32'h0);
        chk("f3_011_nomis", {31'h0, misalign}, 32'h0);
        req(1'b0, 1'b1, 3'b110, 8'h08, 32'hFFFF_FFFF);
        load("f3_110_nowrite", LW, 8'h08, 32'hDEAD_0000);

        store("sw_a5_again", LW, 8'h04, 32'hA5A5_A5A5);
        req(1'b1, 1'b1, LW, 8'h04, 32'h1111_1111);
        chk("rw_vld", {31'h0, rd_valid}, 32'h1);
        chk("rw_old", read_data, 32'hA5A5_A5A5);
        load("rw_new", LW, 8'h04, 32'h1111_1111);

        store("sw_top", LW, 8'hFC, 32'h5A5A_5A5A);
        load("lw_top", LW, 8'hFC, 32'h5A5A_5A5A);

        req(1'b1, 1'b0, LW, 8'h04, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_novld", {31'h0, rd_valid}, 32'h0);
        chk("midrst_data", read_data, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        funct3     = LW;
        address    = 8'hFC;
        write_data = 32'hFFFF_FFFF;
        wait_init("reinit_cycles", n, saw);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("busy_ignored", {31'h0, saw}, 32'h0);
        load("lw_top_cleared", LW, 8'hFC, 32'h0000_0000);
        load("lw_after_rst", LW, 8'h04, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
